// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider_pkg
// Brief    : Shared width default, state encoding and counter sizing.
// Revision : 1.0
// ============================================================================
package seq_restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Must hold the value 2*w itself, not just 2*w-1.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w) + 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider_div_step
// Brief    : One restoring-division step: shift in a dividend bit, trial
//            subtract, keep or restore.
// Revision : 1.0
// ============================================================================
module seq_restoring_divider_div_step
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_s;
  logic [WIDTH:0] w_t;

  // A borrow out of the trial subtraction shows up as T[WIDTH]; when it is
  // clear the difference is < D, so it always fits back into WIDTH bits.
  always_comb begin
    w_s     = {i_r, i_q_msb};
    w_t     = w_s - {1'b0, i_d};
    o_q_bit = ~w_t[WIDTH];
    o_r     = o_q_bit ? w_t[WIDTH-1:0] : w_s[WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider
// Brief    : Iterative unsigned restoring divider, 2*WIDTH / WIDTH, one
//            quotient bit per clock with start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  // Partial remainder is always < D after a step, so WIDTH bits suffice.
  logic [WIDTH-1:0]   r_r;
  logic [2*WIDTH-1:0] r_q;
  logic [WIDTH-1:0]   r_d;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_r_next;
  logic               w_q_bit;

  seq_restoring_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_r     (r_r),
    .i_q_msb (r_q[2*WIDTH-1]),
    .i_d     (r_d),
    .o_r     (w_r_next),
    .o_q_bit (w_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            busy    <= 1'b1;
            r_r     <= '0;
            r_d     <= divisor;
            // A zero divisor preloads the saturated result with no
            // iterations, so it still pays the single completion cycle.
            if (divisor == '0) begin
              r_q   <= '1;
              r_cnt <= '0;
              r_dbz <= 1'b1;
            end else begin
              r_q   <= dividend;
              r_cnt <= CNT_W'(2 * WIDTH);
              r_dbz <= 1'b0;
            end
          end else begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_RUN: begin
          if (r_cnt != '0) begin
            r_r   <= w_r_next;
            r_q   <= {r_q[2*WIDTH-2:0], w_q_bit};
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state     <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= r_q;
            remainder   <= r_r;
            div_by_zero <= r_dbz;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_restoring_divider
// Brief    : Self-checking bench with an expected-result queue for the
//            sequential restoring divider.
// Revision : 1.0
// ============================================================================
module tb_seq_restoring_divider;
  import seq_restoring_divider_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dbz;
    int             lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q   = '1;
      e.r   = '0;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = a / {{W{1'b0}}, b};
      e.r   = W'(a % {{W{1'b0}}, b});
      e.dbz = 1'b0;
      e.lat = 2 * W + 1;
    end
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (b != '0) check("busy_after_accept", 32'(busy), 32'd1);
    check("done_low_after_accept", 32'(done), 32'd0);
  endtask

  // Counts edges from the accept edge until done; returns at the done negedge.
  task automatic wait_done(input bit scramble, input int pulse_at);
    int          n;
    bit          got;
    exp_t        e;
    logic [31:0] recon;
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        if (pulse_at != 0 && n == pulse_at) begin
          dividend = 16'd500;
          divisor  = 8'd5;
          start    = 1'b1;
        end else begin
          start = 1'b0;
        end
        if (scramble) begin
          dividend = 16'($urandom);
          divisor  = 8'($urandom);
        end
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("latency", 32'(n), 32'(e.lat));
      check("quotient", 32'(quotient), 32'(e.q));
      check("remainder", 32'(remainder), 32'(e.r));
      check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      check("busy_low_at_done", 32'(busy), 32'd0);
      if (!e.dbz) begin
        recon = 32'(quotient) * 32'(e.b) + 32'(remainder);
        check("invariant_recon", recon, 32'(e.a));
        check("invariant_rem_lt_div", 32'(remainder < e.b), 32'd1);
      end
    end
  endtask

  task automatic check_pulse_end();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  logic [2*W-1:0] rt_a [6] = '{16'd364, 16'd62500, 16'd65025, 16'd0, 16'd6705, 16'd44823};
  logic [W-1:0]   rt_b [6] = '{8'd13, 8'd250, 8'd255, 8'd255, 8'd149, 8'd223};

  initial begin
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiplier round trip
    for (int i = 0; i < 6; i++) begin
      start_op(rt_a[i], rt_b[i]);
      wait_done(1'b0, 0);
      check_pulse_end();
    end

    // Nonzero remainder and maximum operands
    start_op(16'd65535, 8'd7);   wait_done(1'b0, 0); check_pulse_end();
    start_op(16'd65535, 8'd1);   wait_done(1'b0, 0); check_pulse_end();
    start_op(16'd100,   8'd255); wait_done(1'b0, 0); check_pulse_end();

    // Divide by zero, then a normal op clears the flag
    start_op(16'd1234, 8'd0);    wait_done(1'b0, 0); check_pulse_end();
    start_op(16'd10,   8'd3);    wait_done(1'b0, 0); check_pulse_end();

    // Start pulse while busy is ignored; start during DONE is taken back-to-back
    start_op(16'd1000, 8'd10);
    wait_done(1'b0, 3);
    start_op(16'd9, 8'd2);
    wait_done(1'b0, 0);
    check_pulse_end();

    // Reset mid-run aborts with no done pulse
    start_op(16'd40000, 8'd200);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    void'(sb.pop_front());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no_done_after_abort", 32'(seen), 32'd0);
    start_op(16'd40000, 8'd200);
    wait_done(1'b0, 0);
    check_pulse_end();

    // Random operands with inputs scrambled while running
    for (int i = 0; i < 1000; i++) begin
      start_op(16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)));
      wait_done(1'b1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative restoring divider: 2*WIDTH-bit dividend ÷ WIDTH-bit divisor → 2*WIDTH-bit quotient plus WIDTH-bit remainder; one quotient bit per clock.
- Inverse datapath of the CSA multiplier stage chain. Checks multiplier products by dividing them back down, and serves as the shared unsigned divide resource in the arithmetic block.
- Start/busy/done handshake, with results held stable until the next accepted start.

Parameters:
- WIDTH, 8, divisor and remainder width; dividend and quotient are 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising edge of clk, accepted only when busy=0.
- dividend  input  2*WIDTH  unsigned; captured on accept.
- divisor  input  WIDTH  unsigned; captured on accept.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  2*WIDTH  result, held until the next accept.
- remainder  output  WIDTH  result, held until the next accept.
- div_by_zero  output  1  flag for the latest result, held with it.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done and div_by_zero = 0; quotient, remainder, internal registers and iteration counter = 0. Deassertion takes effect at the next clk edge.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - divisor≠0 → go to RUN. Load R (WIDTH+1 bits) = 0, Q = dividend, D = divisor, count = 2*WIDTH.
  - divisor=0 → go to DONE directly. quotient = all ones, remainder = 0, div_by_zero = 1.
- RUN, each cycle:
  - S = {R[WIDTH-1:0], Q[2*WIDTH-1]}; T = S − {1'b0, D} (WIDTH+1 bits).
  - If T's MSB = 0: R ← T, Q ← {Q[2*WIDTH-2:0], 1}.
  - Else: R ← S, Q ← {Q[2*WIDTH-2:0], 0}.
  - count ← count − 1.
  - After the iteration that takes count 1→0: go to DONE, with quotient ← final Q, remainder ← final R[WIDTH-1:0], div_by_zero ← 0.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start sampled while in DONE is accepted exactly as in IDLE; the next operation begins with no idle gap.
- Latency: accept at edge N → done high in the cycle after edge N+2*WIDTH+1 (17 edges for WIDTH=8). Divide-by-zero: done high after edge N+1.
- busy = 1 throughout RUN only.
- Ignored inputs: start while busy=1 is ignored, and dividend/divisor changes during RUN have no effect.
- Output updates: quotient, remainder and div_by_zero change only on entry to DONE. They are never exposed as partial values mid-run.
- Invariant (divisor≠0): quotient*divisor + remainder == dividend, and remainder < divisor. R never exceeds WIDTH significant bits after a step.
- Boundaries:
  - dividend=0 → quotient 0, remainder 0.
  - divisor=1 → quotient = dividend.
  - Maximum operands must not overflow: dividend all ones with divisor 1.
- Reset mid-RUN: abort immediately to the reset values; no done pulse.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE), the counter width $clog2(2*WIDTH)+1, and the WIDTH default. The multiplier bench reuses the same WIDTH constant.
- One natural sub-module: div_step. It is combinational, takes R, the Q MSB and D, and returns next R and the quotient bit. It keeps the subtract/restore logic separately testable.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Multiplier round trip: 364/13, 62500/250, 65025/255, 0/255, 6705/149, 44823/223 → quotients 28, 250, 255, 0, 45, 201, all with remainder 0 and div_by_zero 0; done exactly 17 edges after each accept.
- Nonzero remainder and max values: 65535/7 → q=9362 r=1; 65535/1 → q=65535 r=0; 100/255 → q=0 r=100.
- Divide by zero: 1234/0 → q=16'hFFFF, r=0, div_by_zero=1, done after 1 edge; next op 10/3 → q=3 r=1 with div_by_zero cleared.
- Handshake: start pulsed with 500/5 while busy from 1000/10 → pulse ignored, result q=100 r=0. Start held during the DONE cycle with 9/2 → accepted back-to-back, result q=4 r=1.
- Reset mid-run: rst_n low 5 cycles into 40000/200 → all outputs 0 immediately and no done pulse. After release, 40000/200 → q=200 r=0.
- Random: 1000 random operand pairs (divisor≠0) checked against the invariant and a reference model; inputs are toggled during RUN to confirm they are ignored.
